fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock FIFO, running entirely in the read clock domain. It takes the raw Gray-coded write pointer from the write domain and synchronises it internally through a configurable N-stage synchroniser. It then generates the binary RAM read address, the Gray read pointer returned to the write side, registered empty / almost-empty flags, an occupancy level and a read-accept strobe. Reads issued while empty are blocked internally, and can optionally be recorded as an underflow error.

Parameters:
AW, 4, address width; FIFO depth = 2**AW; pointers are AW+1 bits wide.
SYNC_STG, 2, number of flops in the write-pointer synchroniser; legal range 2..4.

Ports:
I_RD_CLK  input  1  read clock; the only clock in this block.
I_RD_RST_N  input  1  reset, synchronous, active-low; sampled only on the rising edge of I_RD_CLK.
I_RD_EN  input  1  read request.
I_RD_WR_PTR  input  AW+1  Gray write pointer, unsynchronised, direct from the write domain.
I_RD_AE_THR  input  AW+1  almost-empty threshold (binary); quasi-static.
O_RD_ADDR  output  AW  binary RAM read address.
O_RD_PTR  output  AW+1  registered Gray read pointer, sent to the write domain.
O_RD_EMPTY  output  1  registered empty flag.
O_RD_AEMPTY  output  1  registered almost-empty flag.
O_RD_LEVEL  output  AW+1  registered occupancy, range 0..2**AW.
O_RD_ACK  output  1  combinational strobe: the read is accepted this cycle.
O_RD_UNDERFLOW  output  1  sticky underflow error; see Optional Feature.

Behaviour:
- Reset: all state updates on the I_RD_CLK edge where I_RD_RST_N=0. A low pulse between edges has no effect.
- Values in reset: rd_bin=0, O_RD_PTR=0, O_RD_ADDR=0, synchroniser stages=0, O_RD_EMPTY=1, O_RD_AEMPTY=1, O_RD_LEVEL=0, O_RD_UNDERFLOW=0.
- Read acceptance:
  - O_RD_ACK = I_RD_EN & ~O_RD_EMPTY.
  - rd_bin_next = rd_bin + O_RD_ACK, modulo 2**(AW+1).
  - rd_gray_next = rd_bin_next ^ (rd_bin_next>>1).
  - Both rd_bin and O_RD_PTR register their next values every cycle.
- O_RD_ADDR = rd_bin[AW-1:0]. It wraps from 2**AW-1 to 0 while the pointer MSB toggles.
- Synchroniser:
  - I_RD_WR_PTR passes through SYNC_STG flops to give wr_gray_s.
  - wr_bin_s is the Gray-to-binary conversion of wr_gray_s (XOR prefix from MSB).
- Flags, all computed from next-state values and registered:
  - empty_next = (rd_gray_next == wr_gray_s).
  - level_next = wr_bin_s - rd_bin_next, modulo 2**(AW+1).
  - aempty_next = (level_next <= I_RD_AE_THR).
- Latency:
  - A write-pointer change on the input is reflected in EMPTY, AEMPTY and LEVEL after SYNC_STG+1 rising edges.
  - A read updates ADDR, PTR, EMPTY, AEMPTY and LEVEL on the same edge that accepts it, so there is no extra cycle.
- Simultaneous read and synchronised write increment: LEVEL is unchanged, and EMPTY stays 0.
- Last-entry read: EMPTY rises on the edge that accepts the read. Back-to-back reads therefore never overrun the data.
- Full FIFO:
  - level 2**AW corresponds to the MSBs differing and the lower bits equal; it is reported as 2**AW.
  - Level never exceeds 2**AW for a legal write side.
- Read while empty: the pointer is held and ACK=0; no other state changes.
- I_RD_AE_THR=0: AEMPTY equals EMPTY.
- I_RD_AE_THR >= 2**AW: AEMPTY is held at 1.

Optional Feature:
FIFO_RD_UNDERFLOW_EN
- Defined: O_RD_UNDERFLOW is set on any edge where I_RD_EN=1 and O_RD_EMPTY=1. It stays set until reset.
- Undefined: O_RD_UNDERFLOW is tied to 0 and no flop is inferred. The port always exists.

Decomposition:
- fifo_pkg holds:
  - functions bin2gray and gray2bin, parametrised on width;
  - localparam defaults FIFO_AW_DEF=4 and FIFO_SYNC_STG_DEF=2.
- Sub-module fifo_ptr_sync: generic WIDTH x STAGES synchroniser with synchronous active-low reset. The write-side controller reuses it.

Test Plan (AW=4, SYNC_STG=2, AE_THR=2):
1. Reset: hold RST_N=0 for 3 edges with I_RD_WR_PTR=5'b00111 -> EMPTY=1, AEMPTY=1, LEVEL=0, ADDR=0, PTR=0, UNDERFLOW=0. After release, LEVEL=5 and EMPTY=0 on the 3rd edge.
2. Sync latency: from reset, step I_RD_WR_PTR 0 -> gray(5)=5'b00111 -> EMPTY falls and LEVEL=5, AEMPTY=0 exactly 3 edges later, not earlier.
3. Drain: RD_EN=1 for 6 cycles with level 5 -> ACK=1 for 5 cycles with ADDR 0,1,2,3,4. LEVEL goes 4,3,2,1,0; AEMPTY rises when LEVEL=2; EMPTY rises with the 5th read; the 6th cycle gives ACK=0 and ADDR stays 5.
4. Wrap: write side advances to 16 then to 32 (wraps to 0); read all 32 entries -> ADDR wraps 15->0. PTR is 5'b11000 at bin 16 and returns to 5'b00000. LEVEL is 16 when full, never above.
5. Underflow: RD_EN=1 while EMPTY=1 -> PTR unchanged. With FIFO_RD_UNDERFLOW_EN, UNDERFLOW=1 next edge and stays set through later legal reads until reset. Without the macro, UNDERFLOW stays 0.
6. Reset mid-operation: level 3 with RD_EN=1; a RST_N low glitch between edges gives no change. Holding RST_N low over one edge returns all outputs to reset values on that edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO pointer logic.
// Holds the default geometry and the Gray/binary conversion functions.
// Both controllers use the same pointer encoding.
package fifo_pkg;

    localparam int FIFO_AW_DEF       = 4;
    localparam int FIFO_SYNC_STG_DEF = 2;

    // Working width of the conversion helpers. Callers zero-extend a narrower
    // pointer into this width and cast the result back down. Zero upper bits
    // leave the low bits of both conversions exact, so one pair of functions
    // serves every pointer width up to this size.
    localparam int FIFO_FN_W = 32;

    function automatic logic [FIFO_FN_W-1:0] bin2gray(input logic [FIFO_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [FIFO_FN_W-1:0] gray2bin(input logic [FIFO_FN_W-1:0] g);
        logic [FIFO_FN_W-1:0] b;
        b[FIFO_FN_W-1] = g[FIFO_FN_W-1];
        for (int i = FIFO_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Generic WIDTH x STAGES flop chain that carries a Gray pointer across a clock
// domain boundary. Reset is synchronous and active-low. The write-side
// controller instantiates the same block.
module fifo_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg_q [STAGES];
    logic [WIDTH-1:0] stg_d [STAGES];

    // Each stage takes the previous stage; stage 0 takes the foreign pointer.
    always_comb begin
        stg_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    // Shift the chain, or clear every stage during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stg_q[i] <= stg_d[i];
            end
        end
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO. Everything here runs on I_RD_CLK.
// It synchronises the write pointer, advances the read pointer on accepted
// reads and registers the empty, almost-empty and level flags. The flags are
// computed from next-state pointers, so a read is reflected on its own edge.
// Optional feature: define FIFO_RD_UNDERFLOW_EN to get a sticky underflow flag
// on O_RD_UNDERFLOW. Without it the port is tied to 0.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int AW       = FIFO_AW_DEF,
    parameter int SYNC_STG = FIFO_SYNC_STG_DEF
) (
    input  logic          I_RD_CLK,
    input  logic          I_RD_RST_N,
    input  logic          I_RD_EN,
    input  logic [AW:0]   I_RD_WR_PTR,
    input  logic [AW:0]   I_RD_AE_THR,
    output logic [AW-1:0] O_RD_ADDR,
    output logic [AW:0]   O_RD_PTR,
    output logic          O_RD_EMPTY,
    output logic          O_RD_AEMPTY,
    output logic [AW:0]   O_RD_LEVEL,
    output logic          O_RD_ACK,
    output logic          O_RD_UNDERFLOW
);

    localparam int PW = AW + 1;

    logic [AW:0] wr_gray_s;
    logic [AW:0] wr_bin_s;

    logic [AW:0] rd_bin_q,   rd_bin_d;
    logic [AW:0] rd_gray_q,  rd_gray_d;
    logic [AW:0] level_q,    level_d;
    logic        empty_q,    empty_d;
    logic        aempty_q,   aempty_d;
    logic        ack;

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STG)
    ) u_wr_ptr_sync (
        .clk   (I_RD_CLK),
        .rst_n (I_RD_RST_N),
        .d     (I_RD_WR_PTR),
        .q     (wr_gray_s)
    );

    // Accept reads only when data is present. Derive the next pointers and
    // the flags they imply against the synchronised write pointer.
    always_comb begin
        ack       = I_RD_EN & ~empty_q;
        rd_bin_d  = rd_bin_q + PW'(ack);
        rd_gray_d = PW'(bin2gray(FIFO_FN_W'(rd_bin_d)));
        wr_bin_s  = PW'(gray2bin(FIFO_FN_W'(wr_gray_s)));
        // Modulo subtraction: a full FIFO has differing MSBs and equal low
        // bits, which yields exactly 2**AW.
        level_d   = wr_bin_s - rd_bin_d;
        empty_d   = (rd_gray_d == wr_gray_s);
        // The threshold shares the level's width. A threshold of 2**AW or
        // more keeps the flag high, and a threshold of 0 mirrors empty.
        aempty_d  = (level_d <= I_RD_AE_THR);
    end

    // Pointer and flag registers.
    always_ff @(posedge I_RD_CLK) begin
        if (!I_RD_RST_N) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    logic underflow_q, underflow_d;

    // A read request while empty latches the error until the next reset.
    always_comb begin
        underflow_d = underflow_q | (I_RD_EN & empty_q);
    end

    // Sticky underflow register.
    always_ff @(posedge I_RD_CLK) begin
        if (!I_RD_RST_N) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign O_RD_UNDERFLOW = underflow_q;
`else
    assign O_RD_UNDERFLOW = 1'b0;
`endif

    assign O_RD_ADDR   = rd_bin_q[AW-1:0];
    assign O_RD_PTR    = rd_gray_q;
    assign O_RD_EMPTY  = empty_q;
    assign O_RD_AEMPTY = aempty_q;
    assign O_RD_LEVEL  = level_q;
    assign O_RD_ACK    = ack;

endmodule
